// File: rtl/zap_wb_pkg.sv
// -----------------------------------------------------------------------------
// zap_wb_pkg
//   Shared definitions for the Wishbone tightly-coupled-memory responder:
//   - the lane geometry of the 32-bit data bus (4 byte lanes of 8 bits)
//   - the width of the wait-state counter
//   - the responder FSM state encoding
// -----------------------------------------------------------------------------
package zap_wb_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 8;
  localparam int DATA_W    = NUM_LANES * LANE_W;

  // Wide enough for the largest wait-state setting (7).
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for cyc & stb
    ST_WAIT = 2'd1,  // counting wait states for an accepted request
    ST_RESP = 2'd2,  // one-cycle ack (read data valid here)
    ST_ERR  = 2'd3   // one-cycle err for a rejected request
  } wb_state_e;

endpackage : zap_wb_pkg

// File: rtl/zap_tcm_ram.sv
// -----------------------------------------------------------------------------
// zap_tcm_ram
//   Single-port synchronous RAM, DEPTH_WORDS x 32, with per-byte write enables.
//   Read data is registered: the word addressed on an enabled edge appears on
//   o_rdata after that edge (read-before-write on a same-address write).
//
// Ports
//   i_clk    in   1          clock, rising edge
//   i_en     in   1          access enable (read and/or write this edge)
//   i_we     in   NUM_LANES  byte-lane write enables (qualified by i_en)
//   i_addr   in   AW         word address
//   i_wdata  in   DATA_W     write data
//   o_rdata  out  DATA_W     registered read data
// -----------------------------------------------------------------------------
module zap_tcm_ram
  import zap_wb_pkg::*;
#(
  parameter  int DEPTH_WORDS = 1024,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 i_clk,
  input  logic                 i_en,
  input  logic [NUM_LANES-1:0] i_we,
  input  logic [AW-1:0]        i_addr,
  input  logic [DATA_W-1:0]    i_wdata,
  output logic [DATA_W-1:0]    o_rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the array and its read register deliberately have no reset; a reset
  // loop over a memory prevents RAM inference and would wipe contents that
  // must survive a responder reset.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_en) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (i_we[l]) begin
          mem[i_addr][l*LANE_W +: LANE_W] <= i_wdata[l*LANE_W +: LANE_W];
        end
      end
      o_rdata <= mem[i_addr];
    end
  end

endmodule : zap_tcm_ram

// File: rtl/zap_wb_tcm_responder.sv
// -----------------------------------------------------------------------------
// zap_wb_tcm_responder
//   Wishbone classic slave in front of a local TCM. A request is sampled in
//   IDLE, checked for range and word alignment, optionally delayed by
//   WAIT_STATES cycles, then completed with a one-cycle ack (or err). Writes
//   commit on the edge entering RESP; reads are launched on that same edge so
//   the registered RAM output is valid during RESP. Dropping cyc during WAIT
//   aborts the transfer silently.
//
// Parameters
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, 16..65536)
//   BASE_ADDR    byte base address, aligned to 4*DEPTH_WORDS
//   WAIT_STATES  extra cycles before ack (0..7)
//
// Ports
//   i_clk      in   1   clock, rising edge
//   i_reset_n  in   1   asynchronous active-low reset
//   i_wb_cyc   in   1   bus cycle valid
//   i_wb_stb   in   1   transfer strobe
//   i_wb_we    in   1   1=write, 0=read
//   i_wb_adr   in   32  byte address
//   i_wb_dat   in   32  write data
//   i_wb_sel   in   4   byte lane enables
//   o_wb_dat   out  32  read data (zero outside RESP)
//   o_wb_ack   out  1   transfer complete (registered)
//   o_wb_err   out  1   transfer rejected (registered)
// -----------------------------------------------------------------------------
module zap_wb_tcm_responder
  import zap_wb_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [31:0]          i_wb_adr,
  input  logic [DATA_W-1:0]    i_wb_dat,
  input  logic [NUM_LANES-1:0] i_wb_sel,
  output logic [DATA_W-1:0]    o_wb_dat,
  output logic                 o_wb_ack,
  output logic                 o_wb_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  // First byte-address bit above the RAM window; bits at and above it must
  // match the base for a hit (the base is window-aligned).
  localparam int HI = AW + 2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  wb_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ack_q, err_q;

  // Request captured on the sampling edge.
  logic [AW-1:0]        idx_q;
  logic                 we_q;
  logic [DATA_W-1:0]    dat_q;
  logic [NUM_LANES-1:0] sel_q;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic req;
  logic addr_hit;
  logic addr_aligned;

  assign req          = i_wb_cyc & i_wb_stb;
  assign addr_hit     = (i_wb_adr[31:HI] == BASE_ADDR[31:HI]);
  assign addr_aligned = (i_wb_adr[1:0] == 2'b00);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic capture;   // latch the request this edge
  logic go_resp;   // this edge enters RESP: commit write / launch read

  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    go_resp = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          capture = 1'b1;
          if (!(addr_hit && addr_aligned)) begin
            state_d = ST_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
            go_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end

      ST_WAIT: begin
        // Abort outranks completion, including on the last wait cycle.
        if (!i_wb_cyc) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = ST_RESP;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      // Single-cycle response states; they never look at the bus.
      ST_RESP,
      ST_ERR: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // Derived from a single next-state value, so ack and err can never
      // both be set.
      ack_q   <= (state_d == ST_RESP);
      err_q   <= (state_d == ST_ERR);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_q <= '0;
      we_q  <= 1'b0;
      dat_q <= '0;
      sel_q <= '0;
    end else if (capture) begin
      idx_q <= i_wb_adr[HI-1:2];
      we_q  <= i_wb_we;
      dat_q <= i_wb_dat;
      sel_q <= i_wb_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM port
  //   With zero wait states RESP is entered straight from IDLE, before the
  //   capture registers hold the request, so the live bus feeds the RAM in
  //   IDLE and the captured copy feeds it otherwise.
  // ---------------------------------------------------------------------------
  logic                 in_idle;
  logic [AW-1:0]        ram_addr;
  logic [DATA_W-1:0]    ram_wdata;
  logic [NUM_LANES-1:0] ram_sel;
  logic                 ram_is_write;
  logic [NUM_LANES-1:0] ram_we;
  logic [DATA_W-1:0]    ram_rdata;

  assign in_idle      = (state_q == ST_IDLE);
  assign ram_addr     = in_idle ? i_wb_adr[HI-1:2] : idx_q;
  assign ram_wdata    = in_idle ? i_wb_dat         : dat_q;
  assign ram_sel      = in_idle ? i_wb_sel         : sel_q;
  assign ram_is_write = in_idle ? i_wb_we          : we_q;
  assign ram_we       = ram_sel & {NUM_LANES{go_resp & ram_is_write}};

  zap_tcm_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .i_clk   (i_clk),
    .i_en    (go_resp),
    .i_we    (ram_we),
    .i_addr  (ram_addr),
    .i_wdata (ram_wdata),
    .o_rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  //   Read data is gated by the (async-reset) state, so it drops to zero the
  //   moment reset asserts even though the RAM output register is unreset.
  // ---------------------------------------------------------------------------
  assign o_wb_dat = ((state_q == ST_RESP) && !we_q) ? ram_rdata : '0;
  assign o_wb_ack = ack_q;
  assign o_wb_err = err_q;

endmodule : zap_wb_tcm_responder

// File: tb/tb_zap_wb_tcm_responder.sv
// -----------------------------------------------------------------------------
// tb_zap_wb_tcm_responder
//   Directed bench for zap_wb_tcm_responder at its default parameters
//   (DEPTH_WORDS=1024, BASE_ADDR=0, WAIT_STATES=1). Each scenario task drives
//   the bus and compares outputs against hand-computed values.
// -----------------------------------------------------------------------------
module tb_zap_wb_tcm_responder;

  logic        clk;
  logic        reset_n;
  logic        wb_cyc, wb_stb, wb_we;
  logic [31:0] wb_adr, wb_dat_w;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_r;
  logic        wb_ack, wb_err;

  int checks = 0;
  int errors = 0;

  zap_wb_tcm_responder dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_wb_cyc  (wb_cyc),
    .i_wb_stb  (wb_stb),
    .i_wb_we   (wb_we),
    .i_wb_adr  (wb_adr),
    .i_wb_dat  (wb_dat_w),
    .i_wb_sel  (wb_sel),
    .o_wb_dat  (wb_dat_r),
    .o_wb_ack  (wb_ack),
    .o_wb_err  (wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one transfer from a negedge and waits (bounded) for ack or err.
  // n counts rising edges from the sampling edge (inclusive) to the response;
  // tail reports whether ack/err is still high one cycle after the response.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output int n, output logic got_ack,
                      output logic got_err, output logic [31:0] rdata, output logic tail);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
    n = 0; got_ack = 1'b0; got_err = 1'b0; rdata = '0;
    while (n < 10 && !got_ack && !got_err) begin
      @(posedge clk); #1;
      n++;
      got_ack = wb_ack;
      got_err = wb_err;
      rdata   = wb_dat_r;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    tail = wb_ack | wb_err;
  endtask

  task automatic test_reset();
    if ({wb_ack, wb_err} !== 2'b00) begin
      errors++; $display("FAIL reset_ack_err: got %b expected 00", {wb_ack, wb_err});
    end
    checks++;
    if (wb_dat_r !== 32'h0) begin
      errors++; $display("FAIL reset_dat: got %h expected 00000000", wb_dat_r);
    end
    checks++;
  endtask

  task automatic test_write_read();
    int n; logic a, e, t; logic [31:0] r;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, n, a, e, r, t);
    if (!(n == 2 && a === 1'b1 && e === 1'b0 && t === 1'b0)) begin
      errors++; $display("FAIL wr_latency: got n=%0d ack=%b err=%b tail=%b expected n=2 ack=1 err=0 tail=0", n, a, e, t);
    end
    checks++;
    xfer(1'b0, 32'h10, 32'h0, 4'hF, n, a, e, r, t);
    if (!(n == 2 && a === 1'b1 && e === 1'b0 && t === 1'b0)) begin
      errors++; $display("FAIL rd_latency: got n=%0d ack=%b err=%b tail=%b expected n=2 ack=1 err=0 tail=0", n, a, e, t);
    end
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL rd_data: got %h expected deadbeef", r);
    end
    checks++;
    if (wb_dat_r !== 32'h0) begin
      errors++; $display("FAIL dat_idle: got %h expected 00000000", wb_dat_r);
    end
    checks++;
    // Last word of the window is in range.
    xfer(1'b1, 32'hFFC, 32'h5A5A_A5A5, 4'hF, n, a, e, r, t);
    xfer(1'b0, 32'hFFC, 32'h0, 4'hF, n, a, e, r, t);
    if (!(a === 1'b1 && r === 32'h5A5A_A5A5)) begin
      errors++; $display("FAIL last_word: got ack=%b data=%h expected ack=1 data=5a5aa5a5", a, r);
    end
    checks++;
  endtask

  task automatic test_lanes();
    int n; logic a, e, t; logic [31:0] r;
    xfer(1'b1, 32'h14, 32'h11223344, 4'hF, n, a, e, r, t);
    xfer(1'b1, 32'h14, 32'hAABBCCDD, 4'b0101, n, a, e, r, t);
    xfer(1'b0, 32'h14, 32'h0, 4'hF, n, a, e, r, t);
    if (r !== 32'h11BB33DD) begin
      errors++; $display("FAIL lane_merge: got %h expected 11bb33dd", r);
    end
    checks++;
    xfer(1'b1, 32'h14, 32'hFFFFFFFF, 4'b0000, n, a, e, r, t);
    if (!(a === 1'b1 && e === 1'b0 && n == 2)) begin
      errors++; $display("FAIL sel0_ack: got n=%0d ack=%b err=%b expected n=2 ack=1 err=0", n, a, e);
    end
    checks++;
    xfer(1'b0, 32'h14, 32'h0, 4'hF, n, a, e, r, t);
    if (r !== 32'h11BB33DD) begin
      errors++; $display("FAIL sel0_unchanged: got %h expected 11bb33dd", r);
    end
    checks++;
  endtask

  task automatic test_errors();
    int n; logic a, e, t; logic [31:0] r;
    xfer(1'b1, 32'h0, 32'hCAFE0000, 4'hF, n, a, e, r, t);
    xfer(1'b0, 32'h1000, 32'h0, 4'hF, n, a, e, r, t);
    if (!(n == 1 && a === 1'b0 && e === 1'b1 && t === 1'b0)) begin
      errors++; $display("FAIL err_range: got n=%0d ack=%b err=%b tail=%b expected n=1 ack=0 err=1 tail=0", n, a, e, t);
    end
    checks++;
    xfer(1'b0, 32'h6, 32'h0, 4'hF, n, a, e, r, t);
    if (!(n == 1 && a === 1'b0 && e === 1'b1 && t === 1'b0)) begin
      errors++; $display("FAIL err_align: got n=%0d ack=%b err=%b tail=%b expected n=1 ack=0 err=1 tail=0", n, a, e, t);
    end
    checks++;
    // Rejected writes must not reach the RAM (0x1000 aliases word 0, 0x12 sits in word 4).
    xfer(1'b1, 32'h1000, 32'h12345678, 4'hF, n, a, e, r, t);
    xfer(1'b1, 32'h12, 32'h0, 4'hF, n, a, e, r, t);
    if (e !== 1'b1) begin
      errors++; $display("FAIL err_align_wr: got err=%b expected 1", e);
    end
    checks++;
    xfer(1'b0, 32'h0, 32'h0, 4'hF, n, a, e, r, t);
    if (r !== 32'hCAFE0000) begin
      errors++; $display("FAIL err_ram_w0: got %h expected cafe0000", r);
    end
    checks++;
    xfer(1'b0, 32'h10, 32'h0, 4'hF, n, a, e, r, t);
    if (r !== 32'hDEADBEEF) begin
      errors++; $display("FAIL err_ram_w4: got %h expected deadbeef", r);
    end
    checks++;
  endtask

  task automatic test_abort();
    int n; logic a, e, t; logic [31:0] r; logic seen;
    xfer(1'b1, 32'h20, 32'h01020304, 4'hF, n, a, e, r, t);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h20; wb_dat_w = 32'hFFFFFFFF; wb_sel = 4'hF;
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen |= wb_ack | wb_err;
    end
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_resp: got ack/err=%b expected 0", seen);
    end
    checks++;
    xfer(1'b0, 32'h20, 32'h0, 4'hF, n, a, e, r, t);
    if (r !== 32'h01020304) begin
      errors++; $display("FAIL abort_data: got %h expected 01020304", r);
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    int n; logic a, e, t; logic [31:0] r;
    int acks; int k; int ack_at [4]; logic [31:0] got [4];
    for (int i = 0; i < 4; i++)
      xfer(1'b1, 32'h30 + 32'(4*i), 32'hA000_0000 + 32'(i), 4'hF, n, a, e, r, t);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h30; wb_sel = 4'hF;
    acks = 0; k = 0;
    while (acks < 4 && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (wb_ack) begin
        ack_at[acks] = k;
        got[acks]    = wb_dat_r;
        acks++;
        wb_adr = 32'h30 + 32'(4*acks);
        if (acks == 4) begin
          wb_cyc = 1'b0; wb_stb = 1'b0;
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (wb_ack) acks++;
    end
    if (acks != 4) begin
      errors++; $display("FAIL b2b_count: got %0d acks expected 4", acks);
    end
    checks++;
    if (acks == 4) begin
      for (int i = 0; i < 4; i++) begin
        if (ack_at[i] != 2 + 3*i || got[i] !== 32'hA000_0000 + 32'(i)) begin
          errors++;
          $display("FAIL b2b_ack%0d: got cycle=%0d data=%h expected cycle=%0d data=%h",
                   i, ack_at[i], got[i], 2 + 3*i, 32'hA000_0000 + 32'(i));
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int n; logic a, e, t; logic [31:0] r;
    // Reset in WAIT of a write: write lost.
    xfer(1'b1, 32'h40, 32'h11111111, 4'hF, n, a, e, r, t);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 32'h40; wb_dat_w = 32'h22222222; wb_sel = 4'hF;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    if ({wb_ack, wb_err, wb_dat_r} !== 34'h0) begin
      errors++; $display("FAIL rst_wait_outs: got ack=%b err=%b dat=%h expected 0 0 00000000", wb_ack, wb_err, wb_dat_r);
    end
    checks++;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); reset_n = 1'b1;
    xfer(1'b0, 32'h40, 32'h0, 4'hF, n, a, e, r, t);
    if (!(n == 2 && a === 1'b1 && r === 32'h11111111)) begin
      errors++; $display("FAIL rst_wait_lost: got n=%0d ack=%b data=%h expected n=2 ack=1 data=11111111", n, a, r);
    end
    checks++;
    // Reset during RESP of a read: ack and data drop at once.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h10; wb_sel = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (!(wb_ack === 1'b1 && wb_dat_r === 32'hDEADBEEF)) begin
      errors++; $display("FAIL rst_resp_pre: got ack=%b dat=%h expected 1 deadbeef", wb_ack, wb_dat_r);
    end
    checks++;
    reset_n = 1'b0;
    #1;
    if ({wb_ack, wb_err, wb_dat_r} !== 34'h0) begin
      errors++; $display("FAIL rst_resp_outs: got ack=%b err=%b dat=%h expected 0 0 00000000", wb_ack, wb_err, wb_dat_r);
    end
    checks++;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    xfer(1'b1, 32'h44, 32'h0BADF00D, 4'hF, n, a, e, r, t);
    xfer(1'b0, 32'h44, 32'h0, 4'hF, n, a, e, r, t);
    if (!(n == 2 && a === 1'b1 && r === 32'h0BADF00D)) begin
      errors++; $display("FAIL rst_after: got n=%0d ack=%b data=%h expected n=2 ack=1 data=0badf00d", n, a, r);
    end
    checks++;
  endtask

  initial begin
    reset_n = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); reset_n = 1'b1;
    test_write_read();
    test_lanes();
    test_errors();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_zap_wb_tcm_responder

// File: doc/zap_wb_tcm_responder.md
ZAP_WB_TCM_RESPONDER -- requirements
Module: zap_wb_tcm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, giving the word count of the local RAM (power of two, 16..65536).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, giving the byte base address, aligned to 4*DEPTH_WORDS.
REQ-003 SHALL have parameter WAIT_STATES, default 1, giving extra cycles before ack (0..7).
REQ-004 SHALL have one clock and an asynchronous, active-low reset; both ports are listed below.
REQ-005 SHALL have port i_clk  in  1  clock, rising edge.
REQ-006 SHALL have port i_reset_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port i_wb_cyc  in  1  bus cycle valid.
REQ-008 SHALL have port i_wb_stb  in  1  transfer strobe.
REQ-009 SHALL have port i_wb_we  in  1  1=write, 0=read.
REQ-010 SHALL have port i_wb_adr  in  32  byte address.
REQ-011 SHALL have port i_wb_dat  in  32  write data.
REQ-012 SHALL have port i_wb_sel  in  4  byte lane enables; bit n covers bits 8n+7:8n.
REQ-013 SHALL have port o_wb_dat  out  32  read data.
REQ-014 SHALL have port o_wb_ack  out  1  transfer complete.
REQ-015 SHALL have port o_wb_err  out  1  transfer rejected.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP, ERR.
REQ-017 In IDLE, on a rising edge with i_wb_cyc&i_wb_stb=1, SHALL latch adr, we, dat and sel.
REQ-018 On that edge SHALL go to ERR if adr is outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS) or adr[1:0]!=0.
REQ-019 Otherwise SHALL go to RESP when WAIT_STATES=0, else to WAIT with the wait counter loaded with WAIT_STATES-1.
REQ-020 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-021 Total latency SHALL be WAIT_STATES+1 cycles from the sampling edge to o_wb_ack=1.
REQ-022 A write SHALL update only the lanes enabled by sel, on the edge entering RESP.
REQ-023 A write with sel=0 SHALL still be acked with the RAM unchanged.
REQ-024 A read SHALL drive the word at (adr-BASE_ADDR)>>2 on o_wb_dat, all four lanes, during RESP.
REQ-025 o_wb_dat SHALL be 0 outside RESP.
REQ-026 RESP and ERR SHALL each last exactly one cycle, asserting o_wb_ack (RESP) or o_wb_err (ERR), then return to IDLE.
REQ-027 RESP and ERR SHALL never sample a request; a strobe held high is re-sampled at the earliest in the following IDLE cycle, giving a throughput of one transfer per WAIT_STATES+2 cycles.
REQ-028 o_wb_ack and o_wb_err SHALL be registered and mutually exclusive.
REQ-029 If i_wb_cyc=0 in WAIT, SHALL abort to IDLE with no RAM write and no ack or err.
REQ-030 If i_wb_cyc=0 on the edge leaving WAIT, abort SHALL take priority over the write.
REQ-031 Changes to the inputs after the sampling edge SHALL be ignored until the next IDLE.

Reset
REQ-032 On assertion of i_reset_n=0 SHALL immediately force state=IDLE, counter=0, o_wb_ack=0, o_wb_err=0 and o_wb_dat=0.
REQ-033 Reset SHALL NOT clear RAM contents.
REQ-034 Reset asserted mid-transfer SHALL abandon the transfer; a write not yet committed SHALL be lost.
REQ-035 Deassertion SHALL be synchronized to i_clk in the integrating wrapper; the first request is sampled on the first edge after deassertion.

Structure
REQ-036 Package zap_wb_pkg SHALL hold the FSM state enum and the lane-width constants (4 lanes, 8 bits).
REQ-037 The RAM SHALL be the sub-module zap_tcm_ram: single port, synchronous, per-byte write enables, DEPTH_WORDS x 32.
REQ-038 The read address SHALL be presented to zap_tcm_ram one cycle before RESP, so that data is valid in RESP.
REQ-039 The RAM SHALL be the only inferred memory; all other state SHALL be flops.

Verification (defaults, BASE_ADDR=32'h0000_0000, WAIT_STATES=1)
REQ-040 Write adr=32'h10, dat=32'hDEADBEEF, sel=4'hF, then read 32'h10 -> ack 2 cycles after each strobe; read returns 32'hDEADBEEF.
REQ-041 Over 32'h11223344, write sel=4'b0101 dat=32'hAABBCCDD, then read -> 32'h11BB33DD.
REQ-042 Read adr=32'h1000 (out of range) and adr=32'h6 (misaligned) -> o_wb_err one cycle each, no ack, RAM unchanged.
REQ-043 Write 32'h20 with cyc dropped in WAIT -> no ack or err; later read of 32'h20 returns its prior value.
REQ-044 Strobe held high across 4 reads -> exactly 4 single-cycle acks, spaced 3 cycles apart.
REQ-045 Reset pulsed in WAIT of a write -> outputs 0 immediately, write not committed, next transfer completes normally.
